avalon_lsu: RTL and testbench

Load/store unit between the MIPS core datapath and the Avalon-MM data memory (`RAM_avalon`); it is the bus master directly upstream of the RAM.
- Accepts one byte, halfword or word load/store request at a time and checks alignment.
- Drives `address`, `byteenable`, `read`/`write` and `writedata`, then holds the transfer until `waitrequest` releases it.
- Returns sign- or zero-extended load data, or an error, as a one-cycle response pulse.

---
 rtl/lsu_pkg.sv | 10 +
 rtl/lsu_lane_align.sv | 24 ++
 rtl/avalon_lsu.sv | 90 +++++++++
 tb/tb_avalon_lsu.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: access-size and FSM state enums plus byte-lane constants shared by the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10} lsu_size_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} lsu_state_t;
  localparam int LANES = 4;
  localparam int LANE_W = 8;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_WORD = 4'b1111;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational lane steering (size/offset/sgn/wdata/readdata in; byteenable/writedata/rdata/misaligned out)
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] readdata,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic [31:0] rdata,
  output logic        misaligned
);
  logic [31:0] shifted;
  always_comb begin
    shifted = readdata >> {offset, 3'b000};
    misaligned = (size == 2'b11) || (size == HALF && offset[0]) || (size == WORD && offset != 2'b00);
    byteenable = size == BYTE ? 4'b0001 << offset : size == HALF ? (offset[1] ? BE_HI_HALF : BE_LO_HALF) : BE_WORD;
    writedata = size == BYTE ? {LANES{wdata[LANE_W-1:0]}} : size == HALF ? {2{wdata[15:0]}} : wdata;
    rdata = size == BYTE ? {{24{sgn & shifted[7]}}, shifted[7:0]} :
            size == HALF ? {{16{sgn & shifted[15]}}, shifted[15:0]} : shifted;
  end
endmodule

// File: rtl/avalon_lsu.sv
// avalon_lsu: Avalon-MM load/store master (core req_*/resp_* handshake in, address/byteenable/read/write/writedata out, readdata/waitrequest in)
module avalon_lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] address,
  output logic [3:0]  byteenable,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        waitrequest
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  lsu_state_t state, state_nx;
  logic r_write, r_signed;
  logic [1:0] r_size, a_size, a_off;
  logic [31:0] r_addr, r_wdata, wd, ld;
  logic [3:0] be;
  logic [CW-1:0] cnt;
  logic [CW:0] cnt_inc;
  logic accept, busy, timeout, mis;
  lsu_lane_align u_align (
    .size(a_size),
    .offset(a_off),
    .sgn(r_signed),
    .wdata(r_wdata),
    .readdata(readdata),
    .byteenable(be),
    .writedata(wd),
    .rdata(ld),
    .misaligned(mis)
  );
  always_comb begin
    accept = req_valid && state == IDLE;
    busy = state == ISSUE || state == WAIT;
    a_size = state == IDLE ? req_size : r_size;
    a_off = state == IDLE ? req_addr[1:0] : r_addr[1:0];
    cnt_inc = {1'b0, cnt} + (CW+1)'(1);
    timeout = TIMEOUT_CYCLES != 0 && waitrequest && cnt_inc == (CW+1)'(TIMEOUT_CYCLES);
    state_nx = state == IDLE ? (accept ? (mis ? DONE : ISSUE) : IDLE) :
               state == ISSUE ? WAIT :
               state == WAIT ? ((!waitrequest || timeout) ? DONE : WAIT) : IDLE;
    req_ready = state == IDLE;
    resp_valid = state == DONE;
    read = busy && !r_write;
    write = busy && r_write;
    address = busy ? {r_addr[31:2], 2'b00} : '0;
    byteenable = busy ? be : '0;
    writedata = write ? wd : '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_write <= 1'b0;
      r_signed <= 1'b0;
      r_size <= 2'b00;
      r_addr <= '0;
      r_wdata <= '0;
      cnt <= '0;
      resp_err <= 1'b0;
      resp_rdata <= '0;
    end else begin
      if (accept) begin
        r_write <= req_write;
        r_size <= req_size;
        r_signed <= req_signed;
        r_addr <= req_addr;
        r_wdata <= req_wdata;
      end
      cnt <= state == ISSUE ? '0 : (state == WAIT && !(&cnt)) ? cnt + CW'(1) : cnt;
      resp_err <= state == IDLE ? accept && mis : state == WAIT ? timeout : 1'b0;
      resp_rdata <= (state == WAIT && !waitrequest && !r_write) ? ld : '0;
    end
endmodule

// File: tb/tb_avalon_lsu.sv
// tb_avalon_lsu: randomized self-checking bench for avalon_lsu with an Avalon RAM stub and a byte-level memory model
module tb_avalon_lsu;
  localparam int TO = 8;
  localparam logic [31:0] BASE = 32'hBFC0_0000;
  logic clk = 0, reset_n = 1;
  logic req_valid = 0, req_write = 0, req_signed = 0;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_ready, resp_valid, resp_err, read, write;
  logic [31:0] resp_rdata, address, writedata;
  logic [3:0] byteenable;
  logic [31:0] readdata = 0;
  logic waitrequest = 0;
  int checks = 0, errors = 0;
  logic [31:0] ram [64];
  logic [31:0] model [64];
  int delay = 4;
  bit stuck = 0;
  int wcnt = 0;
  logic cmd_d = 0, mon_d = 0;
  logic poke_en = 0;
  logic [5:0] poke_idx = 0;
  logic [31:0] poke_val = 0;
  int reads = 0, writes = 0, gap = 100, min_gap = 100, last_gap = 100, viol = 0;
  logic [31:0] cap_addr = 0, cap_wd = 0;
  logic [3:0] cap_be = 0;
  logic cap_w = 0;

  avalon_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .address(address), .byteenable(byteenable), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    merge = old;
    for (int k = 0; k < 4; k++) if (be[k]) merge[8*k +: 8] = wd[8*k +: 8];
  endfunction

  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      waitrequest <= 0;
      wcnt <= 0;
      cmd_d <= 0;
    end else begin
      if (poke_en) ram[poke_idx] <= poke_val;
      cmd_d <= read | write;
      if ((read | write) && !cmd_d) begin
        readdata <= delay == 0 ? ram[address[7:2]] : $urandom;
        if (delay == 0 && write) ram[address[7:2]] <= merge(ram[address[7:2]], writedata, byteenable);
        waitrequest <= delay != 0;
        wcnt <= delay;
      end else if (waitrequest && !stuck) begin
        if (wcnt <= 1) begin
          waitrequest <= 0;
          readdata <= ram[address[7:2]];
          if (write) ram[address[7:2]] <= merge(ram[address[7:2]], writedata, byteenable);
        end
        wcnt <= wcnt - 1;
      end
    end

  always @(posedge clk) begin
    mon_d <= read | write;
    if (read | write) begin
      gap <= 0;
      if (!mon_d) begin
        cap_addr <= address;
        cap_be <= byteenable;
        cap_wd <= writedata;
        cap_w <= write;
        last_gap <= gap;
        if (gap < min_gap) min_gap <= gap;
        if (read) reads <= reads + 1;
        if (write) writes <= writes + 1;
      end
      if ((read && write) || (mon_d && {address, byteenable, writedata, write} !== {cap_addr, cap_be, cap_wd, cap_w}))
        viol <= viol + 1;
    end else gap <= gap + 1;
  end

  function automatic bit exp_mis(logic [1:0] sz, logic [1:0] off);
    exp_mis = sz == 2'b11 || (int'(off) % (1 << sz)) != 0;
  endfunction

  function automatic logic [3:0] exp_be(logic [1:0] sz, logic [1:0] off);
    int n;
    n = 1 << sz;
    exp_be = 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] exp_wd(logic [1:0] sz, logic [31:0] d);
    int n;
    n = 1 << sz;
    for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = 8'(d >> (8 * (i % n)));
  endfunction

  function automatic logic [31:0] exp_load(logic [1:0] sz, logic [1:0] off, bit sg, logic [31:0] word);
    int n;
    logic [31:0] mask, v;
    n = 1 << sz;
    mask = n == 4 ? 32'hFFFF_FFFF : (32'h1 << (8 * n)) - 32'h1;
    v = (word >> (8 * off)) & mask;
    if (sg && v[8*n-1]) v = v | ~mask;
    exp_load = v;
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 1 << sz;
    for (int j = 0; j < n; j++) model[a[7:2]][8*(int'(a[1:0]) + j) +: 8] = 8'(d >> (8 * j));
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] v);
    poke_en = 1;
    poke_idx = a[7:2];
    poke_val = v;
    model[a[7:2]] = v;
    @(negedge clk);
    poke_en = 0;
  endtask

  task automatic req(input bit w, input logic [1:0] sz, input bit sg, input logic [31:0] a, input logic [31:0] wd,
                     output bit err, output logic [31:0] rd, output int lat, output bit one_pulse);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 0; req_write = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    err = resp_err;
    rd = resp_rdata;
    @(negedge clk);
    one_pulse = !resp_valid && lat < 40;
  endtask

  task automatic test_reset();
    #2 reset_n = 0;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    checks++; if ({read, write, resp_valid, resp_err} !== 4'b0) begin errors++; $display("FAIL reset_ctl got %b exp 0000", {read, write, resp_valid, resp_err}); end
    checks++; if ({address, byteenable, writedata, resp_rdata} !== 100'b0) begin errors++; $display("FAIL reset_bus got %h exp 0", {address, byteenable, writedata, resp_rdata}); end
    reset_n = 1;
    for (int i = 0; i < 64; i++) poke(BASE + 32'(4 * i), $urandom);
  endtask

  task automatic test_load_word();
    bit err, p; logic [31:0] rd; int lat;
    poke(BASE, 32'h11223344);
    delay = 4;
    req(0, 2'b10, 0, BASE, 0, err, rd, lat, p);
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL lw_data got %h exp 11223344", rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL lw_err got %b exp 0", err); end
    checks++; if (cap_be !== 4'hF) begin errors++; $display("FAIL lw_be got %b exp 1111", cap_be); end
    checks++; if (!p) begin errors++; $display("FAIL lw_pulse got multi/none exp single"); end
    checks++; if (lat !== 7) begin errors++; $display("FAIL lw_latency got %0d exp 7", lat); end
  endtask

  task automatic test_byte_loads();
    bit err, p; logic [31:0] rd; int lat;
    delay = 1;
    req(0, 2'b00, 1, BASE + 2, 0, err, rd, lat, p);
    checks++; if (rd !== 32'h00000022) begin errors++; $display("FAIL lb_pos got %h exp 00000022", rd); end
    checks++; if (cap_be !== 4'b0100) begin errors++; $display("FAIL lb_be got %b exp 0100", cap_be); end
    poke(BASE, 32'h11A23344);
    req(0, 2'b00, 1, BASE + 2, 0, err, rd, lat, p);
    checks++; if (rd !== 32'hFFFFFFA2) begin errors++; $display("FAIL lb_neg got %h exp ffffffa2", rd); end
    req(0, 2'b00, 0, BASE + 2, 0, err, rd, lat, p);
    checks++; if (rd !== 32'h000000A2) begin errors++; $display("FAIL lbu got %h exp 000000a2", rd); end
  endtask

  task automatic test_half_store();
    bit err, p; logic [31:0] rd; int lat;
    poke(BASE + 4, 32'h12345678);
    delay = 2;
    req(1, 2'b01, 0, BASE + 6, 32'h0000BEEF, err, rd, lat, p);
    model_store(2'b01, BASE + 6, 32'h0000BEEF);
    checks++; if (cap_be !== 4'b1100) begin errors++; $display("FAIL sh_be got %b exp 1100", cap_be); end
    checks++; if (cap_wd !== 32'hBEEFBEEF) begin errors++; $display("FAIL sh_wd got %h exp beefbeef", cap_wd); end
    checks++; if ({cap_w, err, rd} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL sh_resp got %b/%b/%h exp 1/0/0", cap_w, err, rd); end
    req(0, 2'b10, 0, BASE + 4, 0, err, rd, lat, p);
    checks++; if (rd !== 32'hBEEF5678) begin errors++; $display("FAIL sh_readback got %h exp beef5678", rd); end
  endtask

  task automatic test_misaligned();
    bit err, p; logic [31:0] rd; int lat, nb;
    logic [1:0] szs [3] = '{2'b10, 2'b01, 2'b11};
    logic [1:0] offs [3] = '{2'd1, 2'd3, 2'd0};
    nb = reads + writes;
    for (int i = 0; i < 3; i++) begin
      req(1'($urandom), szs[i], 0, BASE + 32'(offs[i]), $urandom, err, rd, lat, p);
      checks++; if ({err, rd, p} !== {1'b1, 32'h0, 1'b1}) begin errors++; $display("FAIL mis_resp%0d got %b/%h/%b exp 1/0/1", i, err, rd, p); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL mis_latency%0d got %0d exp 1", i, lat); end
    end
    checks++; if (reads + writes !== nb) begin errors++; $display("FAIL mis_nobus got %0d exp %0d", reads + writes, nb); end
  endtask

  task automatic test_timeout();
    bit err, p; logic [31:0] rd; int lat;
    stuck = 1;
    req(0, 2'b10, 0, BASE, 0, err, rd, lat, p);
    checks++; if ({err, rd, p} !== {1'b1, 32'h0, 1'b1}) begin errors++; $display("FAIL to_resp got %b/%h/%b exp 1/0/1", err, rd, p); end
    checks++; if (lat !== TO + 2) begin errors++; $display("FAIL to_latency got %0d exp %0d", lat, TO + 2); end
    checks++; if (read !== 1'b0) begin errors++; $display("FAIL to_read_drop got %b exp 0", read); end
    stuck = 0;
    delay = TO - 1;
    req(0, 2'b10, 0, BASE + 8, 0, err, rd, lat, p);
    checks++; if ({err, rd} !== {1'b0, model[2]}) begin errors++; $display("FAIL to_edge_ok got %b/%h exp 0/%h", err, rd, model[2]); end
    delay = TO;
    req(0, 2'b10, 0, BASE + 8, 0, err, rd, lat, p);
    checks++; if ({err, lat} !== {1'b1, TO + 2}) begin errors++; $display("FAIL to_edge_err got %b/%0d exp 1/%0d", err, lat, TO + 2); end
    delay = 3;
    req(0, 2'b10, 0, BASE + 12, 0, err, rd, lat, p);
    checks++; if ({err, rd, lat} !== {1'b0, model[3], 6}) begin errors++; $display("FAIL to_recover got %b/%h/%0d exp 0/%h/6", err, rd, lat, model[3]); end
  endtask

  task automatic test_reset_mid();
    int n, seen;
    delay = 20;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    req_valid = 1; req_write = 0; req_size = 2'b10; req_addr = BASE;
    @(negedge clk);
    req_valid = 0;
    repeat (2) @(negedge clk);
    checks++; if (read !== 1'b1) begin errors++; $display("FAIL rm_read_active got %b exp 1", read); end
    #2 reset_n = 0;
    #1;
    checks++; if ({read, req_ready} !== 2'b01) begin errors++; $display("FAIL rm_async got read=%b ready=%b exp 0/1", read, req_ready); end
    @(negedge clk);
    reset_n = 1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid || read) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rm_no_resp got %0d exp 0", seen); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_back_to_back();
    bit err, p; logic [31:0] rd, d; int lat;
    delay = 0;
    d = $urandom;
    req(0, 2'b10, 0, BASE + 16, 0, err, rd, lat, p);
    checks++; if (rd !== model[4]) begin errors++; $display("FAIL b2b_load got %h exp %h", rd, model[4]); end
    req(1, 2'b10, 0, BASE + 16, d, err, rd, lat, p);
    model_store(2'b10, BASE + 16, d);
    checks++; if (last_gap < 2) begin errors++; $display("FAIL b2b_gap got %0d exp >=2", last_gap); end
    req(0, 2'b10, 0, BASE + 16, 0, err, rd, lat, p);
    checks++; if (rd !== d) begin errors++; $display("FAIL b2b_readback got %h exp %h", rd, d); end
  endtask

  task automatic test_random();
    bit err, p, w, sg, mis; logic [31:0] rd, a, d, er; int lat, el, nb; logic [1:0] sz;
    for (int i = 0; i < 60; i++) begin
      sz = 2'($urandom_range(3, 0)); w = 1'($urandom); sg = 1'($urandom);
      a = BASE + 32'($urandom_range(63, 0)); d = $urandom; delay = $urandom_range(5, 0);
      mis = exp_mis(sz, a[1:0]);
      er = (w || mis) ? 32'h0 : exp_load(sz, a[1:0], sg, model[a[7:2]]);
      el = mis ? 1 : (delay == 0 ? 3 : delay + 3);
      nb = reads + writes;
      req(w, sz, sg, a, d, err, rd, lat, p);
      checks++; if ({err, rd, p} !== {mis, er, 1'b1}) begin errors++; $display("FAIL rnd%0d_resp got %b/%h/%b exp %b/%h/1", i, err, rd, p, mis, er); end
      checks++; if (lat !== el) begin errors++; $display("FAIL rnd%0d_latency got %0d exp %0d", i, lat, el); end
      checks++; if (reads + writes !== nb + (mis ? 0 : 1)) begin errors++; $display("FAIL rnd%0d_buscount got %0d exp %0d", i, reads + writes, nb + (mis ? 0 : 1)); end
      if (!mis) begin
        checks++; if ({cap_addr, cap_be, cap_w} !== {a[31:2], 2'b00, exp_be(sz, a[1:0]), w}) begin errors++; $display("FAIL rnd%0d_bus got %h/%b/%b exp %h/%b/%b", i, cap_addr, cap_be, cap_w, {a[31:2], 2'b00}, exp_be(sz, a[1:0]), w); end
        if (w) begin
          checks++; if (cap_wd !== exp_wd(sz, d)) begin errors++; $display("FAIL rnd%0d_wdata got %h exp %h", i, cap_wd, exp_wd(sz, d)); end
          model_store(sz, a, d);
        end
      end
    end
  endtask

  task automatic test_invariants();
    checks++; if (viol !== 0) begin errors++; $display("FAIL bus_stable_excl got %0d exp 0", viol); end
    checks++; if (min_gap < 2) begin errors++; $display("FAIL min_idle_gap got %0d exp >=2", min_gap); end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_byte_loads();
    test_half_store();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
